// File: rtl/external_interrupt_controller.sv
// External interrupt controller: synchronizes two external interrupt lines,
// latches them as pending, masks them with enable bits and presents a single
// request/ID/acknowledge handshake to the core. Control and status registers
// are reachable on the core I/O bus at BASE_ADDR..BASE_ADDR+3.
module external_interrupt_controller #(
   parameter logic [29:0] BASE_ADDR   = 30'h0000_1000,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic        Sys_Clock,
   input  logic        Sys_Reset,
   input  logic [1:0]  Ext_Irq,
   input  logic        IO_EnR,
   input  logic        IO_EnW,
   input  logic [29:0] IO_Address,
   input  logic [31:0] IO_DataW,
   output logic [31:0] IO_DataR,
   output logic        EIC_I_Req,
   output logic        EIC_I_Id,
   input  logic        EIC_I_Ack
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_HOLD = 2'd2;

   localparam logic [1:0] OFF_STATUS   = 2'd0;
   localparam logic [1:0] OFF_ENABLE   = 2'd1;
   localparam logic [1:0] OFF_PEND_CLR = 2'd2;
   localparam logic [1:0] OFF_MODE     = 2'd3;

   logic [1:0][SYNC_STAGES-1:0] r_sync;
   logic [1:0]  r_s_d;
   logic [1:0]  r_pend;
   logic [1:0]  r_enable;
   logic [1:0]  r_mode;
   logic [1:0]  r_state;
   logic        r_req;
   logic        r_id;
   logic [31:0] r_data;

   logic [1:0]  w_s;
   logic [1:0]  w_set;
   logic [1:0]  w_clr;
   logic [1:0]  w_pend_en;
   logic [29:0] w_off;
   logic        w_hit;
   logic        w_we;
   logic [31:0] w_rd_data;
   logic        w_unused;

   // Word offset relative to the register block; a hit covers four words
   assign w_off    = IO_Address - BASE_ADDR;
   assign w_hit    = (w_off[29:2] == '0);
   assign w_we     = IO_EnW & w_hit;
   assign w_unused = &{1'b0, IO_DataW[31:2]};

   assign w_pend_en = r_pend & r_enable;

   // Synchronized level and pending set/clear terms
   always_comb begin
      w_set = '0;
      w_clr = '0;
      w_s   = '0;
      for (int unsigned i = 0; i < 2; i++) begin
         w_s[i]   = r_sync[i][SYNC_STAGES-1];
         w_set[i] = r_mode[i] ? (w_s[i] & ~r_s_d[i]) : w_s[i];
      end
      if (w_we && (w_off[1:0] == OFF_PEND_CLR)) begin
         w_clr = IO_DataW[1:0];
      end
      if ((r_state == ST_REQ) && EIC_I_Ack) begin
         w_clr[r_id] = 1'b1;
      end
   end

   // Register read multiplexer (values before any same-cycle write)
   always_comb begin
      w_rd_data = '0;
      case (w_off[1:0])
         OFF_STATUS:   w_rd_data = {28'b0, w_s, r_pend};
         OFF_ENABLE:   w_rd_data = {30'b0, r_enable};
         OFF_PEND_CLR: w_rd_data = '0;
         OFF_MODE:     w_rd_data = {30'b0, r_mode};
         default:      w_rd_data = '0;
      endcase
   end

   // Synchronizer chains and the delayed copy used for edge detection
   always_ff @(posedge Sys_Clock or posedge Sys_Reset) begin
      if (Sys_Reset) begin
         r_sync <= '0;
         r_s_d  <= '0;
      end else begin
         for (int unsigned i = 0; i < 2; i++) begin
            r_sync[i] <= {r_sync[i][SYNC_STAGES-2:0], Ext_Irq[i]};
         end
         r_s_d <= w_s;
      end
   end

   // Pending latch: a set in the same cycle as a clear takes priority
   always_ff @(posedge Sys_Clock or posedge Sys_Reset) begin
      if (Sys_Reset) begin
         r_pend <= '0;
      end else begin
         r_pend <= (r_pend & ~w_clr) | w_set;
      end
   end

   // ENABLE and MODE control registers
   always_ff @(posedge Sys_Clock or posedge Sys_Reset) begin
      if (Sys_Reset) begin
         r_enable <= '0;
         r_mode   <= '1;
      end else if (w_we) begin
         if (w_off[1:0] == OFF_ENABLE) r_enable <= IO_DataW[1:0];
         if (w_off[1:0] == OFF_MODE)   r_mode   <= IO_DataW[1:0];
      end
   end

   // Registered read data; a read outside the block returns zero
   always_ff @(posedge Sys_Clock or posedge Sys_Reset) begin
      if (Sys_Reset) begin
         r_data <= '0;
      end else if (IO_EnR) begin
         r_data <= w_hit ? w_rd_data : '0;
      end
   end

   // Request handshake: hold request until ack, then force one idle gap
   always_ff @(posedge Sys_Clock or posedge Sys_Reset) begin
      if (Sys_Reset) begin
         r_state <= ST_IDLE;
         r_req   <= 1'b0;
         r_id    <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (|w_pend_en) begin
                  r_state <= ST_REQ;
                  r_req   <= 1'b1;
                  r_id    <= ~w_pend_en[0];
               end
            end
            ST_REQ: begin
               if (EIC_I_Ack) begin
                  r_state <= ST_HOLD;
                  r_req   <= 1'b0;
               end
            end
            ST_HOLD: begin
               if (!EIC_I_Ack) r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
               r_req   <= 1'b0;
            end
         endcase
      end
   end

   assign IO_DataR  = r_data;
   assign EIC_I_Req = r_req;
   assign EIC_I_Id  = r_id;

endmodule

// File: tb/tb_external_interrupt_controller.sv
// Self-checking bench for external_interrupt_controller: register map table
// plus hand-written handshake, priority, level-mode and async-reset sequences.
module tb_external_interrupt_controller;

   localparam logic [29:0] BASE  = 30'h0000_1000;
   localparam logic [29:0] A_ST  = BASE;
   localparam logic [29:0] A_EN  = BASE + 30'd1;
   localparam logic [29:0] A_PC  = BASE + 30'd2;
   localparam logic [29:0] A_MD  = BASE + 30'd3;
   localparam logic [29:0] A_OUT = BASE + 30'd4;
   localparam logic [29:0] A_LOW = BASE - 30'd1;

   logic        Sys_Clock = 1'b0;
   logic        Sys_Reset = 1'b1;
   logic [1:0]  Ext_Irq   = '0;
   logic        IO_EnR    = 1'b0;
   logic        IO_EnW    = 1'b0;
   logic [29:0] IO_Address = '0;
   logic [31:0] IO_DataW  = '0;
   logic [31:0] IO_DataR;
   logic        EIC_I_Req;
   logic        EIC_I_Id;
   logic        EIC_I_Ack = 1'b0;

   int checks   = 0;
   int failures = 0;
   logic [31:0] exp_q[$];

   typedef struct {
      bit          rd;
      bit          wr;
      logic [29:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp;
   } vec_t;

   localparam int NV = 16;
   vec_t vt[NV];

   external_interrupt_controller #(.BASE_ADDR(BASE), .SYNC_STAGES(2)) dut (
      .Sys_Clock (Sys_Clock),
      .Sys_Reset (Sys_Reset),
      .Ext_Irq   (Ext_Irq),
      .IO_EnR    (IO_EnR),
      .IO_EnW    (IO_EnW),
      .IO_Address(IO_Address),
      .IO_DataW  (IO_DataW),
      .IO_DataR  (IO_DataR),
      .EIC_I_Req (EIC_I_Req),
      .EIC_I_Id  (EIC_I_Id),
      .EIC_I_Ack (EIC_I_Ack)
   );

   always #5 Sys_Clock = ~Sys_Clock;

   task automatic tick();
      @(posedge Sys_Clock);
      #1;
   endtask

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   task automatic io_write(input logic [29:0] a, input logic [31:0] d);
      IO_EnW = 1'b1; IO_Address = a; IO_DataW = d;
      tick();
      IO_EnW = 1'b0;
   endtask

   task automatic io_read(input string nm, input logic [29:0] a, input logic [31:0] e);
      logic [31:0] x;
      IO_EnR = 1'b1; IO_Address = a;
      exp_q.push_back(e);
      tick();
      IO_EnR = 1'b0;
      x = exp_q.pop_front();
      check(nm, IO_DataR, x);
   endtask

   task automatic wait_req(input string nm);
      int n = 0;
      while (!EIC_I_Req && n < 20) begin
         tick();
         n++;
      end
      check(nm, {31'b0, EIC_I_Req}, 32'd1);
   endtask

   initial begin
      // rd, wr, addr, wdata, expected read data
      vt[0]  = '{1'b1, 1'b0, A_EN,  32'h0,         32'h0};
      vt[1]  = '{1'b1, 1'b0, A_MD,  32'h0,         32'h3};
      vt[2]  = '{1'b0, 1'b1, A_EN,  32'hFFFF_FFFF, 32'h0};
      vt[3]  = '{1'b1, 1'b0, A_EN,  32'h0,         32'h3};
      vt[4]  = '{1'b0, 1'b1, A_MD,  32'hFFFF_FFFE, 32'h0};
      vt[5]  = '{1'b1, 1'b0, A_MD,  32'h0,         32'h2};
      vt[6]  = '{1'b1, 1'b1, A_EN,  32'h1,         32'h3};
      vt[7]  = '{1'b1, 1'b0, A_EN,  32'h0,         32'h1};
      vt[8]  = '{1'b1, 1'b0, A_PC,  32'h0,         32'h0};
      vt[9]  = '{1'b1, 1'b0, A_ST,  32'h0,         32'h0};
      vt[10] = '{1'b0, 1'b1, A_OUT, 32'hFF,        32'h0};
      vt[11] = '{1'b1, 1'b0, A_EN,  32'h0,         32'h1};
      vt[12] = '{1'b1, 1'b0, A_OUT, 32'h0,         32'h0};
      vt[13] = '{1'b1, 1'b0, A_EN,  32'h0,         32'h1};
      vt[14] = '{1'b1, 1'b0, A_LOW, 32'h0,         32'h0};
      vt[15] = '{1'b0, 1'b1, A_MD,  32'h3,         32'h0};

      #2;
      check("rst_req", {31'b0, EIC_I_Req}, 32'd0);
      check("rst_id",  {31'b0, EIC_I_Id},  32'd0);
      check("rst_data", IO_DataR, 32'd0);
      #10 Sys_Reset = 1'b0;
      tick();

      // Register map table
      for (int i = 0; i < NV; i++) begin
         IO_EnR = vt[i].rd; IO_EnW = vt[i].wr;
         IO_Address = vt[i].addr; IO_DataW = vt[i].wdata;
         if (vt[i].rd) exp_q.push_back(vt[i].exp);
         tick();
         IO_EnR = 1'b0; IO_EnW = 1'b0;
         if (vt[i].rd) check($sformatf("vec%0d", i), IO_DataR, exp_q.pop_front());
      end
      io_read("rd_en_before_hold", A_EN, 32'h1);
      tick();
      check("rd_hold", IO_DataR, 32'h1);
      io_write(A_EN, 32'h0);

      // Single edge source: exact latency, ack, no re-request
      io_write(A_EN, 32'h1);
      Ext_Irq = 2'b01;
      for (int n = 1; n <= 4; n++) begin
         tick();
         if (n == 3) Ext_Irq = 2'b00;
         check($sformatf("lat_req_e%0d", n), {31'b0, EIC_I_Req}, (n == 4) ? 32'd1 : 32'd0);
      end
      check("lat_id", {31'b0, EIC_I_Id}, 32'd0);
      EIC_I_Ack = 1'b1;
      tick();
      check("ack_drop", {31'b0, EIC_I_Req}, 32'd0);
      EIC_I_Ack = 1'b0;
      for (int n = 0; n < 4; n++) begin
         tick();
         check("no_rereq", {31'b0, EIC_I_Req}, 32'd0);
      end
      io_read("pend_cleared", A_ST, 32'h0);

      // Simultaneous edges: source 0 first, then source 1
      io_write(A_EN, 32'h3);
      Ext_Irq = 2'b11;
      tick();
      Ext_Irq = 2'b00;
      wait_req("both_req");
      check("both_id0", {31'b0, EIC_I_Id}, 32'd0);
      EIC_I_Ack = 1'b1;
      tick();
      check("both_ack0", {31'b0, EIC_I_Req}, 32'd0);
      io_read("status_pend10", A_ST, 32'h2);
      io_read("rd_out_range", A_OUT, 32'h0);
      EIC_I_Ack = 1'b0;
      tick();
      check("hold_gap", {31'b0, EIC_I_Req}, 32'd0);
      tick();
      check("second_req", {31'b0, EIC_I_Req}, 32'd1);
      check("second_id1", {31'b0, EIC_I_Id}, 32'd1);

      // No retraction while requesting
      io_write(A_EN, 32'h0);
      for (int n = 0; n < 3; n++) begin
         check("noretract_req", {31'b0, EIC_I_Req}, 32'd1);
         check("noretract_id", {31'b0, EIC_I_Id}, 32'd1);
         tick();
      end
      EIC_I_Ack = 1'b1;
      tick();
      check("ack1_drop", {31'b0, EIC_I_Req}, 32'd0);
      EIC_I_Ack = 1'b0;
      tick();
      io_read("pend_all_clear", A_ST, 32'h0);

      // Level mode on source 0
      io_write(A_MD, 32'h2);
      io_write(A_EN, 32'h1);
      Ext_Irq = 2'b01;
      wait_req("lvl_req");
      check("lvl_id", {31'b0, EIC_I_Id}, 32'd0);
      EIC_I_Ack = 1'b1;
      tick();
      check("lvl_ack", {31'b0, EIC_I_Req}, 32'd0);
      EIC_I_Ack = 1'b0;
      tick();
      check("lvl_gap", {31'b0, EIC_I_Req}, 32'd0);
      tick();
      check("lvl_rereq", {31'b0, EIC_I_Req}, 32'd1);
      io_write(A_PC, 32'h1);
      io_read("lvl_clr_loses", A_ST, 32'h5);
      check("lvl_still_req", {31'b0, EIC_I_Req}, 32'd1);

      // Asynchronous reset in the middle of a request
      #3 Sys_Reset = 1'b1;
      #1;
      check("arst_req", {31'b0, EIC_I_Req}, 32'd0);
      check("arst_id",  {31'b0, EIC_I_Id},  32'd0);
      check("arst_data", IO_DataR, 32'd0);
      Ext_Irq = 2'b00;
      #10 Sys_Reset = 1'b0;
      tick();
      io_read("arst_en", A_EN, 32'h0);
      io_read("arst_mode", A_MD, 32'h3);
      io_read("arst_status", A_ST, 32'h0);
      check("arst_idle", {31'b0, EIC_I_Req}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
